rank_match_sched: RTL and testbench

Sequencer for the shared XOR template-match engine in the card-recognition pipeline. After a rank corner has been captured into the engine's mask buffer, this block steps the engine through every stored rank template one at a time. It collects each mismatch score and reports the template with the lowest score as the recognised rank. It sits between the card-corner locator, which issues `start`, and the game-logic consumer, which reads `best_idx` when `result_valid` pulses.

---
 rtl/rank_match_sched.sv | 215 +++++++++++++++++++++
 tb/tb_rank_match_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rank_match_sched.sv
// rank_match_sched
// Sequencer for the shared XOR template-match engine. After a rank corner is
// captured, it launches one engine compare per stored template, collects each
// mismatch score and publishes the index of the lowest-scoring template.
// A template whose engine never answers is abandoned after TIMEOUT cycles and
// scored as all-ones.
//
// Optional feature macro: RANK_REJECT_EN
//   defined   : no_match is raised when the best score exceeds REJECT_THRESH.
//   undefined : no_match is tied low and no threshold comparator is built.
`timescale 1ns/1ps

module rank_match_sched #(
    parameter  int unsigned NUM_TEMPLATES = 13,
    parameter  int unsigned KERNEL_SIZE   = 1120,
    parameter  int unsigned TIMEOUT       = 2048,
    parameter  int unsigned REJECT_THRESH = 300,
    localparam int unsigned SCORE_W       = $clog2(KERNEL_SIZE + 1),
    localparam int unsigned IDX_W         = $clog2(NUM_TEMPLATES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               eng_start,
    output logic [IDX_W-1:0]   eng_sel,
    input  logic               eng_done,
    input  logic [SCORE_W-1:0] eng_score,
    output logic               busy,
    output logic               result_valid,
    output logic [IDX_W-1:0]   best_idx,
    output logic [SCORE_W-1:0] best_score,
    output logic               timeout_flag,
    output logic               no_match
);

    // Wait counter only has to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_TEMPLATES - 1);
    localparam logic [SCORE_W-1:0] SCORE_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q,        state_d;
    logic [IDX_W-1:0]   idx_q,          idx_d;
    logic [CNT_W-1:0]   wait_cnt_q,     wait_cnt_d;
    logic [SCORE_W-1:0] cur_score_q,    cur_score_d;
    logic [SCORE_W-1:0] run_best_q,     run_best_d;
    logic [IDX_W-1:0]   run_idx_q,      run_idx_d;
    logic               eng_start_q,    eng_start_d;
    logic               busy_q,         busy_d;
    logic               result_valid_q, result_valid_d;
    logic [IDX_W-1:0]   best_idx_q,     best_idx_d;
    logic [SCORE_W-1:0] best_score_q,   best_score_d;
    logic               timeout_flag_q, timeout_flag_d;

`ifdef RANK_REJECT_EN
    localparam logic [SCORE_W-1:0] THRESH = SCORE_W'(REJECT_THRESH);
    logic no_match_q, no_match_d;
`else
    localparam int unsigned REJECT_THRESH_UNUSED = REJECT_THRESH;
`endif

    // Next-state and datapath: abort dominates, then the per-state sweep steps.
    // Output registers are loaded from the next state so every output changes
    // on the same edge as the state it belongs to.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        wait_cnt_d     = wait_cnt_q;
        cur_score_d    = cur_score_q;
        run_best_d     = run_best_q;
        run_idx_d      = run_idx_q;
        best_idx_d     = best_idx_q;
        best_score_d   = best_score_q;
        timeout_flag_d = timeout_flag_q;
`ifdef RANK_REJECT_EN
        no_match_d     = no_match_q;
`endif

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d        = S_LAUNCH;
                        idx_d          = '0;
                        run_best_d     = SCORE_ONES;
                        run_idx_d      = '0;
                        timeout_flag_d = 1'b0;
`ifdef RANK_REJECT_EN
                        no_match_d     = 1'b0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        cur_score_d = eng_score;
                        state_d     = S_COMPARE;
                    end else if ((wait_cnt_q + CNT_W'(1)) == TMO_LAST) begin
                        // Launch cycle plus TIMEOUT-1 wait cycles elapsed.
                        cur_score_d    = SCORE_ONES;
                        timeout_flag_d = 1'b1;
                        state_d        = S_COMPARE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                S_COMPARE: begin
                    // Strict less-than keeps the lower index on ties.
                    if (cur_score_q < run_best_q) begin
                        run_best_d = cur_score_q;
                        run_idx_d  = idx_q;
                    end else begin
                        run_best_d = run_best_q;
                        run_idx_d  = run_idx_q;
                    end
                    if (idx_q < IDX_LAST) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LAUNCH;
                    end else begin
                        // Publish now so the result is visible in the DONE cycle.
                        state_d      = S_DONE;
                        best_score_d = run_best_d;
                        best_idx_d   = run_idx_d;
`ifdef RANK_REJECT_EN
                        no_match_d   = (run_best_d > THRESH);
`endif
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        eng_start_d    = (state_d == S_LAUNCH);
        busy_d         = (state_d != S_IDLE);
        result_valid_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            wait_cnt_q     <= '0;
            cur_score_q    <= '0;
            run_best_q     <= '0;
            run_idx_q      <= '0;
            eng_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            best_idx_q     <= '0;
            best_score_q   <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            wait_cnt_q     <= wait_cnt_d;
            cur_score_q    <= cur_score_d;
            run_best_q     <= run_best_d;
            run_idx_q      <= run_idx_d;
            eng_start_q    <= eng_start_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            best_idx_q     <= best_idx_d;
            best_score_q   <= best_score_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

`ifdef RANK_REJECT_EN
    // Reject flag register, cleared by reset and by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            no_match_q <= 1'b0;
        end else begin
            no_match_q <= no_match_d;
        end
    end

    assign no_match = no_match_q;
`else
    assign no_match = 1'b0;
`endif

    // The template index register doubles as the engine select, so it is held
    // from LAUNCH through COMPARE automatically.
    assign eng_sel      = idx_q;
    assign eng_start    = eng_start_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign best_idx     = best_idx_q;
    assign best_score   = best_score_q;
    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_rank_match_sched.sv
// Testbench for rank_match_sched: table of sweep vectors (engine latency,
// scores, dead templates, abort point) with hand-computed expected results,
// followed by hand-written reset and start/abort sequences.
`timescale 1ns/1ps

module tb_rank_match_sched;

    localparam int NT      = 13;
    localparam int TMO     = 16;
    localparam int SW      = 11;
    localparam int IW      = 4;
    localparam int BUDGET  = 400;
    localparam int ONES    = 2047;
`ifdef RANK_REJECT_EN
    localparam bit REJ = 1'b1;
`else
    localparam bit REJ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          eng_start;
    logic [IW-1:0] eng_sel;
    logic          eng_done = 1'b0;
    logic [SW-1:0] eng_score = '0;
    logic          busy;
    logic          result_valid;
    logic [IW-1:0] best_idx;
    logic [SW-1:0] best_score;
    logic          timeout_flag;
    logic          no_match;

    rank_match_sched #(
        .NUM_TEMPLATES (NT),
        .KERNEL_SIZE   (1120),
        .TIMEOUT       (TMO),
        .REJECT_THRESH (300)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .eng_start    (eng_start),
        .eng_sel      (eng_sel),
        .eng_done     (eng_done),
        .eng_score    (eng_score),
        .busy         (busy),
        .result_valid (result_valid),
        .best_idx     (best_idx),
        .best_score   (best_score),
        .timeout_flag (timeout_flag),
        .no_match     (no_match)
    );

    always #5 clk = ~clk;

    // dead: -1 none, -2 every template, else index the engine never answers.
    // abort_sel: -1 none, else abort two cycles after that template launches.
    typedef struct packed {
        int                  lat;
        int                  dead;
        int                  abort_sel;
        bit [NT-1:0][SW-1:0] sc;
        int                  exp_rv;
        int                  exp_launches;
        int                  exp_idx;
        int                  exp_score;
        bit                  exp_tmo;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    int cur_vec = -1;
    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (vec %0d): got %0d, expected %0d", name, cur_vec, act, exp);
        end
    endtask

    function automatic vec_t mk(input int lat, input int dead, input int abort_sel,
                                input int fill, input int exp_rv, input int exp_launches,
                                input int exp_idx, input int exp_score, input bit exp_tmo);
        vec_t v;
        v.lat = lat; v.dead = dead; v.abort_sel = abort_sel;
        for (int i = 0; i < NT; i++) v.sc[i] = SW'(fill);
        v.exp_rv = exp_rv; v.exp_launches = exp_launches;
        v.exp_idx = exp_idx; v.exp_score = exp_score; v.exp_tmo = exp_tmo;
        return v;
    endfunction

    // Drive one sweep, acting as the engine, and check the published result.
    task automatic run_vec(input vec_t v);
        int fire_at, fire_score, abort_at, rv_cyc, nl, seq_err, lc0, lc_dead, lc_next;
        fire_at = -1; fire_score = 0; abort_at = -1; rv_cyc = -1;
        nl = 0; seq_err = 0; lc0 = -1; lc_dead = -1; lc_next = -1;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (cyc == 1) begin
                    chk("busy_cycle1", int'(busy), 1);
                    chk("eng_start_cycle1", int'(eng_start), 1);
                end
                if (abort_at >= 0 && cyc == abort_at + 1) begin
                    chk("abort_busy_low", int'(busy), 0);
                    chk("abort_no_launch", int'(eng_start), 0);
                end
                if (eng_start) begin
                    if (int'(eng_sel) != nl) seq_err++;
                    if (nl == 0) lc0 = cyc;
                    if (v.dead >= 0 && int'(eng_sel) == v.dead) lc_dead = cyc;
                    if (v.dead >= 0 && int'(eng_sel) == v.dead + 1) lc_next = cyc;
                    nl++;
                    if (v.abort_sel == int'(eng_sel)) abort_at = cyc + 2;
                    if (!(v.dead == -2 || v.dead == int'(eng_sel))) begin
                        fire_at    = cyc + v.lat;
                        fire_score = int'(v.sc[eng_sel]);
                    end
                end
                if (result_valid) begin
                    rv_cyc = cyc;
                    break;
                end
            end
            start     = (cyc == 0) || (v.abort_sel >= 0 && (cyc == 10 || cyc == abort_at));
            abort     = (cyc == abort_at);
            eng_done  = (cyc == fire_at) || (cyc == abort_at);
            eng_score = eng_done ? SW'(fire_score) : '0;
        end
        start = 1'b0; abort = 1'b0; eng_done = 1'b0; eng_score = '0;
        chk("result_valid_cycle", rv_cyc, v.exp_rv);
        chk("launch_count", nl, v.exp_launches);
        chk("launch_order", seq_err, 0);
        chk("first_launch_cycle", lc0, 1);
        chk("best_idx", int'(best_idx), v.exp_idx);
        chk("best_score", int'(best_score), v.exp_score);
        chk("timeout_flag", int'(timeout_flag), int'(v.exp_tmo));
        chk("no_match", int'(no_match),
            (v.exp_rv >= 0) ? int'(REJ && (v.exp_score > 300)) : 0);
        if (v.dead >= 0 && v.dead < NT - 1)
            chk("timeout_launch_gap", lc_next - lc_dead, TMO + 1);
        if (rv_cyc >= 0) begin
            @(negedge clk);
            chk("busy_after_result", int'(busy), 0);
            chk("result_valid_pulse", int'(result_valid), 0);
        end
    endtask

    initial begin
        int found, bad;

        // lat, dead, abort_sel, fill, rv, launches, idx, score, tmo
        vecs[0] = mk(5, -1, -1, 900, 92, 13, 7, 12, 1'b0);
        for (int i = 0; i < 7; i++) vecs[0].sc[i] = SW'(500 - 20 * i);
        vecs[0].sc[7] = SW'(12);
        vecs[1] = mk(3, 4, -1, 600, 78, 13, 2, 50, 1'b1);
        vecs[1].sc[2] = SW'(50);
        vecs[2] = mk(5, -1, 6, 100, -1, 7, 2, 50, 1'b0);
        vecs[3] = mk(1, -1, -1, 200, 40, 13, 3, 40, 1'b0);
        vecs[3].sc[3] = SW'(40);
        vecs[3].sc[9] = SW'(40);
        vecs[4] = mk(2, -1, -1, 1120, 53, 13, 0, 1120, 1'b0);
        vecs[5] = mk(1, -1, -1, 1000, 40, 13, 12, 301, 1'b0);
        vecs[5].sc[12] = SW'(301);
        vecs[6] = mk(1, -1, -1, 301, 40, 13, 0, 300, 1'b0);
        vecs[6].sc[0] = SW'(300);
        vecs[7] = mk(14, -1, -1, 1, 209, 13, 5, 0, 1'b0);
        vecs[7].sc[5] = SW'(0);
        vecs[8] = mk(1, -2, -1, 0, 222, 13, 0, ONES, 1'b1);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_eng_start", int'(eng_start), 0);
        chk("reset_eng_sel", int'(eng_sel), 0);
        chk("reset_best_score", int'(best_score), 0);
        chk("reset_result_valid", int'(result_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
        end

        // Asynchronous reset in the middle of WAIT for template 2.
        cur_vec = 100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (eng_start && eng_sel == IW'(2)) found = 1;
        end
        chk("reach_template2", found, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_eng_sel", int'(eng_sel), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_best_score", int'(best_score), 0);
        chk("async_rst_timeout_flag", int'(timeout_flag), 0);
        chk("async_rst_no_match", int'(no_match), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        eng_done = 1'b1; eng_score = SW'(3);
        @(negedge clk);
        eng_done = 1'b0; eng_score = '0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busy || eng_start || result_valid) bad++;
        end
        chk("late_done_ignored", bad, 0);

        // start and abort together in IDLE: no sweep.
        cur_vec = 101;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle_busy", int'(busy), 0);
        chk("start_abort_idle_launch", int'(eng_start), 0);
        @(negedge clk);
        chk("start_abort_idle_busy2", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
